row_dispatch_scheduler: RTL and testbench

- Sequences the four matrix-multiplication cores of the quadcore machine.
- On a start request it hands out result-row indices one at a time to idle cores and tracks per-core completion.
- Reports overall progress on the machine's 2-bit status, where 3 means finished.
- Sits between the top-level start_process/status pins and the per-core start/done handshakes.

---
 rtl/row_dispatch_scheduler_pkg.sv | 15 +
 rtl/row_dispatch_scheduler_if.sv | 29 ++
 rtl/row_dispatch_scheduler_prio_pick_lowest.sv | 23 ++
 rtl/row_dispatch_scheduler.sv | 142 ++++++++++++++
 tb/tb_row_dispatch_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/row_dispatch_scheduler_pkg.sv
// Shared definitions for the row dispatch scheduler: state encoding (equal to the
// status pin values) and default sizing.
package row_dispatch_scheduler_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int ROW_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/row_dispatch_scheduler_if.sv
// Per-core start/done handshake bundle between the scheduler (master) and the
// matrix-multiplication cores (slave).
interface row_dispatch_scheduler_if
  import row_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ROW_W     = ROW_W_DEF
);

  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0]       core_en;
  logic [NUM_CORES*ROW_W-1:0] core_row;
  logic [NUM_CORES-1:0]       core_done;

  modport master (
    output core_start,
    output core_en,
    output core_row,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_en,
    input  core_row,
    output core_done
  );

endinterface

// File: rtl/row_dispatch_scheduler_prio_pick_lowest.sv
// Fixed-priority picker: one-hot grant to the lowest-index requesting bit,
// plus a valid flag when any bit requests.
module prio_pick_lowest #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  // seen[i] is set when any bit below i already requested
  logic [N:0] seen;

  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_pick
    assign grant[gi]    = req[gi] & ~seen[gi];
    assign seen[gi + 1] = seen[gi] | req[gi];
  end

  assign valid = seen[N];

endmodule

// File: rtl/row_dispatch_scheduler.sv
// Hands result-row indices to idle cores one per cycle, tracks per-core
// completion and reports job progress on a 2-bit status.
module row_dispatch_scheduler
  import row_dispatch_scheduler_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ROW_W     = ROW_W_DEF
) (
  input  logic                         fast_clock,
  input  logic                         reset_n,
  input  logic                         start_process,
  input  logic [ROW_W-1:0]             num_rows,
  row_dispatch_scheduler_if.master     core,
  output logic [1:0]                   status,
  output logic [ROW_W-1:0]             rows_done,
  output logic                         err
);

  state_t                 state_reg, state_next;
  logic                   start_prev_reg;
  logic [NUM_CORES-1:0]   busy_reg, busy_next;
  logic [ROW_W-1:0]       next_row_reg, next_row_next;
  logic [ROW_W-1:0]       rows_done_reg, rows_done_next;
  logic [ROW_W-1:0]       nrows_reg, nrows_next;
  logic                   err_reg, err_next;
  logic [ROW_W-1:0]       core_row_reg [NUM_CORES];
  logic [NUM_CORES*ROW_W-1:0] core_row_flat;

  logic                   start_edge;
  logic                   dispatch;
  logic [NUM_CORES-1:0]   idle_vec;
  logic [NUM_CORES-1:0]   grant;
  logic                   grant_valid;
  logic [NUM_CORES-1:0]   core_start_c;
  logic [NUM_CORES-1:0]   done_ok;
  logic [NUM_CORES-1:0]   done_bad;
  logic [ROW_W-1:0]       done_cnt;

  assign start_edge = start_process & ~start_prev_reg;
  assign idle_vec   = ~busy_reg;

  prio_pick_lowest #(.N(NUM_CORES)) u_pick (
    .req   (idle_vec),
    .grant (grant),
    .valid (grant_valid)
  );

  assign dispatch     = (state_reg == ST_DISPATCH) && grant_valid && (next_row_reg < nrows_reg);
  assign core_start_c = dispatch ? grant : '0;

  // Completion pulses are ignored in IDLE; a pulse from an idle core only flags err
  assign done_ok  = (state_reg != ST_IDLE) ? (core.core_done & busy_reg)  : '0;
  assign done_bad = (state_reg != ST_IDLE) ? (core.core_done & ~busy_reg) : '0;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + ROW_W'(done_ok[i]);
    end
  end

  always_comb begin
    state_next     = state_reg;
    busy_next      = (busy_reg & ~done_ok) | core_start_c;
    next_row_next  = next_row_reg;
    rows_done_next = rows_done_reg + done_cnt;
    nrows_next     = nrows_reg;
    err_next       = err_reg | (|done_bad);

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          nrows_next     = num_rows;
          next_row_next  = '0;
          rows_done_next = '0;
          err_next       = 1'b0;
          state_next     = (num_rows == '0) ? ST_DONE : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (dispatch) begin
          next_row_next = next_row_reg + ROW_W'(1);
          if (next_row_reg == nrows_reg - ROW_W'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((busy_reg == '0) && (rows_done_reg == nrows_reg)) begin
          state_next = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge fast_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      start_prev_reg <= 1'b0;
      busy_reg       <= '0;
      next_row_reg   <= '0;
      rows_done_reg  <= '0;
      nrows_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= start_process;
      busy_reg       <= busy_next;
      next_row_reg   <= next_row_next;
      rows_done_reg  <= rows_done_next;
      nrows_reg      <= nrows_next;
      err_reg        <= err_next;
    end
  end

  // Each core's row index is held until that core is started again
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_row
    always_ff @(posedge fast_clock or negedge reset_n) begin
      if (!reset_n) begin
        core_row_reg[gi] <= '0;
      end else if (core_start_c[gi]) begin
        core_row_reg[gi] <= next_row_reg;
      end
    end
  end

  always_comb begin
    core_row_flat = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_row_flat[i*ROW_W +: ROW_W] = core_row_reg[i];
    end
  end

  assign core.core_start = core_start_c;
  assign core.core_en    = busy_reg | core_start_c;
  assign core.core_row   = core_row_flat;
  assign status          = state_reg;
  assign rows_done       = rows_done_reg;
  assign err             = err_reg;

endmodule

// File: tb/tb_row_dispatch_scheduler.sv
// Directed bench for row_dispatch_scheduler: traces status/rows_done/err per cycle
// and logs every core start (cycle, core, row) against hand-computed tables.
module tb_row_dispatch_scheduler;

  localparam int NC = 4;
  localparam int RW = 8;

  logic          fast_clock    = 1'b0;
  logic          reset_n       = 1'b0;
  logic          start_process = 1'b0;
  logic [RW-1:0] num_rows      = '0;
  logic [1:0]    status;
  logic [RW-1:0] rows_done;
  logic          err;

  row_dispatch_scheduler_if #(.NUM_CORES(NC), .ROW_W(RW)) cif ();

  row_dispatch_scheduler #(.NUM_CORES(NC), .ROW_W(RW)) dut (
    .fast_clock    (fast_clock),
    .reset_n       (reset_n),
    .start_process (start_process),
    .num_rows      (num_rows),
    .core          (cif.master),
    .status        (status),
    .rows_done     (rows_done),
    .err           (err)
  );

  always #5 fast_clock = ~fast_clock;

  int checks = 0;
  int errors = 0;
  int rel;
  int log_n;
  int pend_slot;
  int log_core [16];
  int log_row  [16];
  int log_cyc  [16];
  int st_tr [64];
  int rd_tr [64];
  int er_tr [64];
  int cnt   [NC];
  int onehot_viol = 0;
  bit auto_resp;
  logic [NC-1:0] manual_nxt;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One cycle: sample at the falling edge, log starts, then drive core_done
  task automatic tick();
    logic [NC-1:0] d;
    @(negedge fast_clock);
    if (rel < 63) rel++;
    st_tr[rel] = int'(status);
    rd_tr[rel] = int'(rows_done);
    er_tr[rel] = int'(err);
    if (pend_slot >= 0) begin
      log_row[pend_slot] = int'(cif.core_row[log_core[pend_slot]*RW +: RW]);
      pend_slot = -1;
    end
    if ($countones(cif.core_start) > 1) onehot_viol++;
    d = '0;
    for (int k = 0; k < NC; k++) begin
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) d[k] = 1'b1;
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (cif.core_start[k]) begin
        if (log_n < 16) begin
          log_core[log_n] = k;
          log_cyc[log_n]  = rel;
          pend_slot       = log_n;
        end
        log_n++;
        if (auto_resp) cnt[k] = 3;
      end
    end
    cif.core_done = auto_resp ? d : manual_nxt;
    manual_nxt = '0;
  endtask

  task automatic begin_job(input int n);
    num_rows      = RW'(n);
    start_process = 1'b1;
    rel           = 0;
    log_n         = 0;
    pend_slot     = -1;
  endtask

  task automatic check_log(input string tag, input int i, input int c, input int r, input int cy);
    check_eq($sformatf("%s_core%0d", tag, i), log_core[i], c);
    check_eq($sformatf("%s_row%0d", tag, i), log_row[i], r);
    check_eq($sformatf("%s_cyc%0d", tag, i), log_cyc[i], cy);
  endtask

  int b_core [6] = '{0, 1, 2, 3, 0, 1};
  int s_core [8] = '{0, 1, 2, 3, 1, 3, 0, 1};
  int s_cyc  [8] = '{1, 2, 3, 4, 6, 7, 9, 10};

  initial begin
    cif.core_done = '0;
    manual_nxt    = '0;
    pend_slot     = -1;
    rel           = 0;
    log_n         = 0;
    auto_resp     = 1'b0;
    for (int k = 0; k < NC; k++) cnt[k] = 0;

    repeat (2) tick();
    check_eq("rst_status", int'(status), 0);
    check_eq("rst_rows_done", int'(rows_done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_core_en", int'(cif.core_en), 0);
    check_eq("rst_core_start", int'(cif.core_start), 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-job: cores 0 and 1 busy, core 2 being started
    begin_job(8);
    repeat (3) tick();
    check_eq("mid_pre_start", int'(cif.core_start), 4);
    check_eq("mid_pre_en", int'(cif.core_en), 7);
    reset_n = 1'b0;
    start_process = 1'b0;
    #1;
    check_eq("mid_rst_status", int'(status), 0);
    check_eq("mid_rst_start", int'(cif.core_start), 0);
    check_eq("mid_rst_en", int'(cif.core_en), 0);
    check_eq("mid_rst_rows_done", int'(rows_done), 0);
    pend_slot = -1;
    log_n = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check_eq("mid_no_starts", log_n, 0);
    check_eq("mid_idle_status", int'(status), 0);

    // Basic job, 6 rows, cores answer 3 cycles after start
    auto_resp = 1'b1;
    begin_job(6);
    repeat (12) tick();
    check_eq("basic_nstarts", log_n, 6);
    for (int i = 0; i < 6; i++) check_log("basic", i, b_core[i], i, i + 1);
    check_eq("basic_st1", st_tr[1], 1);
    check_eq("basic_st6", st_tr[6], 1);
    check_eq("basic_st7", st_tr[7], 2);
    check_eq("basic_st10", st_tr[10], 2);
    check_eq("basic_st11", st_tr[11], 3);
    check_eq("basic_rd9", rd_tr[9], 5);
    check_eq("basic_rd11", rd_tr[11], 6);
    check_eq("basic_err", er_tr[11], 0);

    // start_process held high through DONE must not restart
    repeat (5) tick();
    check_eq("hold_status", int'(status), 3);
    check_eq("hold_nstarts", log_n, 6);

    // Zero-row job goes straight to DONE
    start_process = 1'b0;
    tick();
    begin_job(0);
    repeat (4) tick();
    check_eq("zero_st1", st_tr[1], 3);
    check_eq("zero_rd1", rd_tr[1], 0);
    check_eq("zero_nstarts", log_n, 0);

    // Simultaneous done on cores 1 and 3
    auto_resp = 1'b0;
    start_process = 1'b0;
    tick();
    begin_job(8);
    repeat (4) tick();
    manual_nxt = 4'b1010;
    tick();
    repeat (2) tick();
    manual_nxt = 4'b1111;
    tick();
    repeat (2) tick();
    manual_nxt = 4'b0011;
    tick();
    repeat (3) tick();
    check_eq("sim_nstarts", log_n, 8);
    for (int i = 0; i < 8; i++) check_log("sim", i, s_core[i], i, s_cyc[i]);
    check_eq("sim_rd5", rd_tr[5], 0);
    check_eq("sim_rd6", rd_tr[6], 2);
    check_eq("sim_rd9", rd_tr[9], 6);
    check_eq("sim_rd12", rd_tr[12], 8);
    check_eq("sim_st10", st_tr[10], 1);
    check_eq("sim_st11", st_tr[11], 2);
    check_eq("sim_st13", st_tr[13], 3);
    check_eq("sim_err", er_tr[13], 0);

    // Restart with 2 rows; stray done from idle core 2 raises err
    start_process = 1'b0;
    tick();
    begin_job(2);
    repeat (2) tick();
    manual_nxt = 4'b0100;
    tick();
    tick();
    manual_nxt = 4'b0011;
    tick();
    repeat (3) tick();
    check_eq("rs_nstarts", log_n, 2);
    check_log("rs", 0, 0, 0, 1);
    check_log("rs", 1, 1, 1, 2);
    check_eq("rs_rd1", rd_tr[1], 0);
    check_eq("rs_st3", st_tr[3], 2);
    check_eq("rs_err3", er_tr[3], 0);
    check_eq("rs_err4", er_tr[4], 1);
    check_eq("rs_rd4", rd_tr[4], 0);
    check_eq("rs_rd6", rd_tr[6], 2);
    check_eq("rs_st7", st_tr[7], 3);
    check_eq("rs_err8", er_tr[8], 1);

    // Next accepted start edge clears err
    start_process = 1'b0;
    tick();
    begin_job(1);
    repeat (4) tick();
    check_eq("ec_err1", er_tr[1], 0);
    check_eq("ec_st1", st_tr[1], 1);
    check_eq("ec_st2", st_tr[2], 2);
    check_eq("ec_nstarts", log_n, 1);
    check_log("ec", 0, 0, 0, 1);

    check_eq("onehot_start", onehot_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
